// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the scoreboarded integer register file.
// master = pipeline side (decode + writeback), slave = regfile_sb.
interface regfile_sb_if;
  localparam int REG_BUS = 64;

  logic               w_ena;
  logic [4:0]         w_addr;
  logic [REG_BUS-1:0] w_data;
  logic               r1_ena;
  logic [4:0]         r1_addr;
  logic [REG_BUS-1:0] r1_data;
  logic               r1_busy;
  logic               r2_ena;
  logic [4:0]         r2_addr;
  logic [REG_BUS-1:0] r2_data;
  logic               r2_busy;
  logic               raw_stall;
  logic               busy_set;
  logic [4:0]         busy_addr;
  logic               sb_err;

  modport master (
    output w_ena, w_addr, w_data,
    output r1_ena, r1_addr, r2_ena, r2_addr,
    output busy_set, busy_addr,
    input  r1_data, r1_busy, r2_data, r2_busy, raw_stall, sb_err
  );

  modport slave (
    input  w_ena, w_addr, w_data,
    input  r1_ena, r1_addr, r2_ena, r2_addr,
    input  busy_set, busy_addr,
    output r1_data, r1_busy, r2_data, r2_busy, raw_stall, sb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// 32 x 64-bit register file with a 2-bit pending-write counter per register.
// Optional REGFILE_BYPASS_EN forwards a same-cycle writeback to the read ports.
module regfile_sb (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int REG_BUS = 64;

  logic [31:0][REG_BUS-1:0] regs_reg;
  logic [31:0][REG_BUS-1:0] regs_next;
  logic [31:0][1:0]         cnt_reg;
  logic [31:0][1:0]         cnt_next;
  logic [31:0]              err_hit;
  logic                     sb_err_reg;
  logic                     sb_err_next;

  // Entry 0 is x0: never written, never claimed, so its flops stay zero.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs_next[gi] = '0;
        assign cnt_next[gi]  = 2'd0;
        assign err_hit[gi]   = 1'b0;
      end else begin : g_live
        logic       set_hit;
        logic       ret_hit;
        logic [1:0] cnt_upd;
        logic       err_upd;

        assign set_hit = bus.busy_set && (bus.busy_addr == 5'(gi));
        assign ret_hit = bus.w_ena && (bus.w_addr == 5'(gi));

        // A claim and a retire on the same register in one cycle cancel out.
        always_comb begin
          cnt_upd = cnt_reg[gi];
          err_upd = 1'b0;
          case ({set_hit, ret_hit})
            2'b10: begin
              if (cnt_reg[gi] == 2'd3) err_upd = 1'b1;
              else                     cnt_upd = cnt_reg[gi] + 2'd1;
            end
            2'b01: begin
              if (cnt_reg[gi] == 2'd0) err_upd = 1'b1;
              else                     cnt_upd = cnt_reg[gi] - 2'd1;
            end
            default: cnt_upd = cnt_reg[gi];
          endcase
        end

        assign regs_next[gi] = ret_hit ? bus.w_data : regs_reg[gi];
        assign cnt_next[gi]  = cnt_upd;
        assign err_hit[gi]   = err_upd;
      end
    end
  endgenerate

  assign sb_err_next = sb_err_reg | (|err_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_reg   <= '0;
      cnt_reg    <= '0;
      sb_err_reg <= 1'b0;
    end else begin
      regs_reg   <= regs_next;
      cnt_reg    <= cnt_next;
      sb_err_reg <= sb_err_next;
    end
  end

  // Two identical read ports, flattened into arrays.
  logic [1:0]              rd_ena;
  logic [1:0][4:0]         rd_addr;
  logic [1:0][REG_BUS-1:0] rd_data;
  logic [1:0]              rd_busy;

  assign rd_ena  = {bus.r2_ena, bus.r1_ena};
  assign rd_addr = {bus.r2_addr, bus.r1_addr};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [1:0]         cnt_cur;
      logic [1:0]         cnt_eff;
      logic [REG_BUS-1:0] stored;
      logic [REG_BUS-1:0] data_eff;
      logic               addr_nz;

      assign addr_nz = (rd_addr[gi] != 5'd0);
      assign cnt_cur = cnt_reg[rd_addr[gi]];
      assign stored  = regs_reg[rd_addr[gi]];

`ifdef REGFILE_BYPASS_EN
      logic fwd;
      assign fwd = bus.w_ena && (bus.w_addr == rd_addr[gi]) && addr_nz;
      // Busy reflects the count after this cycle's retire; saturate an
      // erroneous retire at zero rather than letting it wrap.
      assign cnt_eff  = !fwd ? cnt_cur :
                        (cnt_cur == 2'd0) ? 2'd0 : 2'(cnt_cur - 2'd1);
      assign data_eff = fwd ? bus.w_data : stored;
`else
      assign cnt_eff  = cnt_cur;
      assign data_eff = stored;
`endif

      assign rd_data[gi] = (rst || !rd_ena[gi] || !addr_nz) ? '0 : data_eff;
      assign rd_busy[gi] = !rst && addr_nz && (cnt_eff != 2'd0);
    end
  endgenerate

  assign bus.r1_data   = rd_data[0];
  assign bus.r2_data   = rd_data[1];
  assign bus.r1_busy   = rd_busy[0];
  assign bus.r2_busy   = rd_busy[1];
  assign bus.raw_stall = |(rd_ena & rd_busy);
  assign bus.sb_err    = sb_err_reg;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; expectations follow
// REGFILE_BYPASS_EN when the bench is compiled with it.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  regfile_sb_if bus ();

  regfile_sb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic idle();
    bus.w_ena = 0; bus.w_addr = 0; bus.w_data = '0;
    bus.busy_set = 0; bus.busy_addr = 0;
  endtask

  // Advance past one rising edge; inputs are then changed 1 time unit later.
  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    idle();
    bus.r1_ena = 0; bus.r1_addr = 0; bus.r2_ena = 0; bus.r2_addr = 0;
    rst = 1; #3; rst = 0;
    cycle();
  endtask

  task automatic test_reset();
    idle();
    bus.r1_ena = 1; bus.r1_addr = 5; bus.r2_ena = 0; bus.r2_addr = 0;
    #1;
    checks++; if (bus.r1_data !== 64'd0) begin errors++; $display("FAIL reset_in_rst_data: got %h want 0", bus.r1_data); end
    rst = 0;
    cycle(); #1;
    checks++; if (bus.r1_data !== 64'd0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.r1_data); end
    checks++; if (bus.r1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.r1_busy); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err: got %b want 0", bus.sb_err); end
    // Write + claim in one cycle leaves the counter at 0 without error.
    bus.w_ena = 1; bus.w_addr = 5; bus.w_data = 64'hDEAD_BEEF_0123_4567;
    bus.busy_set = 1; bus.busy_addr = 5;
    cycle(); idle(); #1;
    checks++; if (bus.r1_data !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL write_x5: got %h want deadbeef01234567", bus.r1_data); end
    checks++; if (bus.r1_busy !== 1'b0 || bus.sb_err !== 1'b0) begin errors++; $display("FAIL write_x5_flags: got busy=%b err=%b want 0 0", bus.r1_busy, bus.sb_err); end
    bus.r1_ena = 0; #1;
    checks++; if (bus.r1_data !== 64'd0) begin errors++; $display("FAIL read_disabled: got %h want 0", bus.r1_data); end
    $display("test_reset done");
  endtask

  task automatic test_x0();
    bus.r1_ena = 1; bus.r1_addr = 0;
    bus.busy_set = 1; bus.busy_addr = 0;
    cycle(); idle();
    bus.w_ena = 1; bus.w_addr = 0; bus.w_data = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    checks++; if (bus.r1_data !== 64'd0) begin errors++; $display("FAIL x0_fwd_data: got %h want 0", bus.r1_data); end
    cycle(); idle(); #1;
    checks++; if (bus.r1_data !== 64'd0) begin errors++; $display("FAIL x0_data: got %h want 0", bus.r1_data); end
    checks++; if (bus.r1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b want 0", bus.r1_busy); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL x0_sb_err: got %b want 0", bus.sb_err); end
    $display("test_x0 done");
  endtask

  task automatic test_raw_stall();
    bus.r1_ena = 0; bus.r1_addr = 7;
    bus.r2_ena = 1; bus.r2_addr = 7;
    #1;
    checks++; if (bus.raw_stall !== 1'b0) begin errors++; $display("FAIL raw_before_claim: got %b want 0", bus.raw_stall); end
    bus.busy_set = 1; bus.busy_addr = 7;
    cycle(); idle(); #1;
    checks++; if (bus.raw_stall !== 1'b1) begin errors++; $display("FAIL raw_after_claim: got %b want 1", bus.raw_stall); end
    checks++; if (bus.r1_busy !== 1'b1) begin errors++; $display("FAIL r1_busy_no_ena: got %b want 1", bus.r1_busy); end
    cycle(); #1;
    checks++; if (bus.raw_stall !== 1'b1) begin errors++; $display("FAIL raw_hold: got %b want 1", bus.raw_stall); end
    bus.w_ena = 1; bus.w_addr = 7; bus.w_data = 64'h0000_1111_2222_3333; #1;
    checks++; if (bus.raw_stall !== !BYP) begin errors++; $display("FAIL raw_retire_cycle: got %b want %b", bus.raw_stall, !BYP); end
    checks++; if (bus.r2_data !== (BYP ? 64'h0000_1111_2222_3333 : 64'd0)) begin errors++; $display("FAIL r2_retire_data: got %h want %h", bus.r2_data, BYP ? 64'h0000_1111_2222_3333 : 64'd0); end
    checks++; if (bus.r1_data !== 64'd0) begin errors++; $display("FAIL r1_disabled_fwd: got %h want 0", bus.r1_data); end
    cycle(); idle(); #1;
    checks++; if (bus.raw_stall !== 1'b0) begin errors++; $display("FAIL raw_after_retire: got %b want 0", bus.raw_stall); end
    checks++; if (bus.r2_data !== 64'h0000_1111_2222_3333) begin errors++; $display("FAIL r2_after_retire: got %h want 0000111122223333", bus.r2_data); end
    $display("test_raw_stall done");
  endtask

  task automatic test_waw();
    bus.r1_ena = 1; bus.r1_addr = 3; bus.r2_ena = 0; bus.r2_addr = 0;
    for (int k = 0; k < 3; k++) begin
      bus.busy_set = 1; bus.busy_addr = 3;
      cycle();
    end
    idle(); #1;
    checks++; if (bus.r1_busy !== 1'b1 || bus.sb_err !== 1'b0) begin errors++; $display("FAIL waw_three_claims: got busy=%b err=%b want 1 0", bus.r1_busy, bus.sb_err); end
    bus.busy_set = 1; bus.busy_addr = 3;
    cycle(); idle(); #1;
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL waw_overflow_err: got %b want 1", bus.sb_err); end
    for (int k = 1; k <= 3; k++) begin
      bus.w_ena = 1; bus.w_addr = 3; bus.w_data = 64'(k); #1;
      if (k == 3) begin
        checks++; if (bus.r1_busy !== !BYP) begin errors++; $display("FAIL waw_last_retire_cycle: got %b want %b", bus.r1_busy, !BYP); end
      end
      cycle(); idle(); #1;
      checks++; if (bus.r1_busy !== (k < 3)) begin errors++; $display("FAIL waw_retire_%0d: got busy=%b want %b", k, bus.r1_busy, k < 3); end
    end
    checks++; if (bus.r1_data !== 64'd3) begin errors++; $display("FAIL waw_final_data: got %h want 3", bus.r1_data); end
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL waw_err_sticky: got %b want 1", bus.sb_err); end
    apply_reset();
    $display("test_waw done");
  endtask

  task automatic test_set_retire();
    bus.r1_ena = 1; bus.r1_addr = 10; bus.r2_ena = 1; bus.r2_addr = 11;
    bus.busy_set = 1; bus.busy_addr = 10;
    cycle(); idle();
    bus.busy_set = 1; bus.busy_addr = 10;
    bus.w_ena = 1; bus.w_addr = 10; bus.w_data = 64'hA;
    cycle(); idle(); #1;
    checks++; if (bus.r1_busy !== 1'b1 || bus.sb_err !== 1'b0) begin errors++; $display("FAIL same_addr_set_retire: got busy=%b err=%b want 1 0", bus.r1_busy, bus.sb_err); end
    // Retire x10 while claiming x11: independent counters.
    bus.w_ena = 1; bus.w_addr = 10; bus.w_data = 64'hB;
    bus.busy_set = 1; bus.busy_addr = 11;
    cycle(); idle(); #1;
    checks++; if (bus.r1_busy !== 1'b0 || bus.r2_busy !== 1'b1) begin errors++; $display("FAIL diff_addr_update: got r1_busy=%b r2_busy=%b want 0 1", bus.r1_busy, bus.r2_busy); end
    checks++; if (bus.sb_err !== 1'b0 || bus.r1_data !== 64'hB) begin errors++; $display("FAIL diff_addr_state: got err=%b data=%h want 0 b", bus.sb_err, bus.r1_data); end
    bus.r1_addr = 9;
    bus.w_ena = 1; bus.w_addr = 9; bus.w_data = 64'h9999_0000_9999_0000;
    cycle(); idle(); #1;
    checks++; if (bus.r1_data !== 64'h9999_0000_9999_0000) begin errors++; $display("FAIL underflow_data: got %h want 9999000099990000", bus.r1_data); end
    checks++; if (bus.sb_err !== 1'b1 || bus.r1_busy !== 1'b0) begin errors++; $display("FAIL underflow_err: got err=%b busy=%b want 1 0", bus.sb_err, bus.r1_busy); end
    apply_reset();
    $display("test_set_retire done");
  endtask

  task automatic test_async_reset();
    bus.r1_ena = 1; bus.r1_addr = 4; bus.r2_ena = 1; bus.r2_addr = 4;
    bus.busy_set = 1; bus.busy_addr = 4;
    bus.w_ena = 1; bus.w_addr = 4; bus.w_data = 64'h4444_4444_4444_4444;
    cycle(); idle();
    for (int k = 0; k < 2; k++) begin
      bus.busy_set = 1; bus.busy_addr = 4;
      if (k == 0) begin bus.w_ena = 1; bus.w_addr = 12; bus.w_data = 64'h12; end
      cycle(); idle();
    end
    #1;
    checks++; if (bus.r1_busy !== 1'b1 || bus.raw_stall !== 1'b1 || bus.sb_err !== 1'b1) begin errors++; $display("FAIL pre_async: got busy=%b stall=%b err=%b want 1 1 1", bus.r1_busy, bus.raw_stall, bus.sb_err); end
    checks++; if (bus.r1_data !== 64'h4444_4444_4444_4444) begin errors++; $display("FAIL pre_async_data: got %h want 4444444444444444", bus.r1_data); end
    #1; rst = 1; #1;
    checks++; if (bus.r1_busy !== 1'b0 || bus.raw_stall !== 1'b0 || bus.sb_err !== 1'b0) begin errors++; $display("FAIL async_drop: got busy=%b stall=%b err=%b want 0 0 0", bus.r1_busy, bus.raw_stall, bus.sb_err); end
    checks++; if (bus.r1_data !== 64'd0) begin errors++; $display("FAIL async_data: got %h want 0", bus.r1_data); end
    #1; rst = 0;
    cycle(); #1;
    checks++; if (bus.r1_data !== 64'd0 || bus.r1_busy !== 1'b0) begin errors++; $display("FAIL after_release: got data=%h busy=%b want 0 0", bus.r1_data, bus.r1_busy); end
    $display("test_async_reset done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_x0();
    test_raw_stall();
    test_waw();
    test_set_retire();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
